// File: rtl/noc_serial_transmitter_if.sv
// Flit link between NoC nodes: valid/ready handshake carrying one data flit plus
// a last-flit marker.
interface node_port #(
    parameter int unsigned DATA_BITS = 16
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data;
    logic                 last;

    modport up (output valid, output data, output last, input ready);
    modport down (input valid, input data, input last, output ready);
endinterface

// File: rtl/noc_serial_transmitter.sv
// Injection-side serialiser: captures {padding, packet} and emits it LSB flit first
// on a node_port, marking the final flit with last.
module noc_serial_transmitter #(
    parameter int unsigned PACKET_BITS    = 40,
    parameter int unsigned PADDING_BITS   = 8,
    parameter int unsigned FLIT_DATA_BITS = 16,
    localparam int unsigned PadW = (PADDING_BITS > 0) ? PADDING_BITS : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   valid,
    output logic                   ready,
    input  logic [PACKET_BITS-1:0] packet,
    input  logic [PadW-1:0]        padding,
    node_port.up                   up,
    output logic                   busy
);
    localparam int unsigned TotalBits = PACKET_BITS + PADDING_BITS;
    localparam int unsigned NumFlits  = (TotalBits + FLIT_DATA_BITS - 1) / FLIT_DATA_BITS;
    localparam int unsigned ShW       = NumFlits * FLIT_DATA_BITS;
    localparam int unsigned CntW      = $clog2(NumFlits + 1);
    // Count value of the flit just before the last one; only used when NumFlits >= 2.
    localparam logic [CntW-1:0] PenultCnt = CntW'((NumFlits >= 2) ? NumFlits - 2 : 0);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e          state_q;
    logic [ShW-1:0]  shreg_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;
    logic            busy_q;
    logic            valid_q;
    logic            last_q;
    logic [ShW-1:0]  word;

    if (PADDING_BITS > 0) begin : g_pad
        assign word = ShW'({padding, packet});
    end else begin : g_nopad
        logic unused_pad;
        assign unused_pad = ^padding;
        assign word       = ShW'(packet);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid) begin
                        state_q <= StSend;
                        shreg_q <= word;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        last_q  <= (NumFlits == 1);
                    end
                end
                StSend: begin
                    if (up.ready) begin
                        if (last_q) begin
                            state_q <= StIdle;
                            shreg_q <= '0;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            shreg_q <= shreg_q >> FLIT_DATA_BITS;
                            cnt_q   <= cnt_q + 1'b1;
                            last_q  <= (cnt_q == PenultCnt);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign up.valid = valid_q;
    assign up.last  = last_q;
    assign up.data  = shreg_q[FLIT_DATA_BITS-1:0];
endmodule

// File: tb/tb_noc_serial_transmitter.sv
// Bench for noc_serial_transmitter: flit-queue model checked every cycle plus
// directed literal checks, and a padding-free 20-bit instance for the partial flit.
module tb_noc_serial_transmitter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [39:0] packet = '0;
    logic [7:0]  padding = '0;
    logic        ready;
    logic        busy;

    logic        valid5 = 1'b0;
    logic [19:0] packet5 = '0;
    logic        ready5;
    logic        busy5;

    int n_checks = 0;
    int n_fail = 0;
    int exp_words = 0;
    int seen_lasts = 0;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } flit_t;
    flit_t exp_q[$];

    node_port #(.DATA_BITS(16)) up_if ();
    node_port #(.DATA_BITS(16)) up5 ();

    noc_serial_transmitter #(
        .PACKET_BITS(40), .PADDING_BITS(8), .FLIT_DATA_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid(valid), .ready(ready),
        .packet(packet), .padding(padding), .up(up_if.up), .busy(busy)
    );

    noc_serial_transmitter #(
        .PACKET_BITS(20), .PADDING_BITS(0), .FLIT_DATA_BITS(16)
    ) dut5 (
        .clk(clk), .rst(rst), .flush(1'b0), .valid(valid5), .ready(ready5),
        .packet(packet5), .padding(1'b0), .up(up5.up), .busy(busy5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word becomes a queue of flits; each accept pops one, flush/rst drop them.
    always @(posedge clk) begin
        if (up_if.valid === 1'b1 && up_if.ready && up_if.last === 1'b1 && !rst) seen_lasts++;
        if (rst) begin
            exp_q.delete();
        end else if (flush) begin
            if (exp_q.size() > 0 && up_if.ready && exp_q[0].last) exp_words++;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (up_if.ready) begin
                if (exp_q[0].last) exp_words++;
                void'(exp_q.pop_front());
            end
        end else if (valid) begin
            logic [47:0] w;
            w = {padding, packet};
            for (int i = 0; i < 3; i++) begin
                flit_t f;
                f.data = w[16*i +: 16];
                f.last = (i == 2);
                exp_q.push_back(f);
            end
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("idle_valid", 64'(up_if.valid), 64'd0);
            check("idle_last", 64'(up_if.last), 64'd0);
            check("idle_ready", 64'(ready), 64'd1);
            check("idle_busy", 64'(busy), 64'd0);
        end else begin
            check("send_valid", 64'(up_if.valid), 64'd1);
            check("send_ready", 64'(ready), 64'd0);
            check("send_busy", 64'(busy), 64'd1);
            check("send_data", 64'(up_if.data), 64'(exp_q[0].data));
            check("send_last", 64'(up_if.last), 64'(exp_q[0].last));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [39:0] p, input logic [7:0] d);
        valid   = 1'b1;
        packet  = p;
        padding = d;
        tick();
        valid = 1'b0;
    endtask

    task automatic lit(input string name, input logic [15:0] data, input logic last);
        check({name, "_valid"}, 64'(up_if.valid), 64'd1);
        check({name, "_data"}, 64'(up_if.data), 64'(data));
        check({name, "_last"}, 64'(up_if.last), 64'(last));
    endtask

    initial begin
        up_if.ready = 1'b1;
        up5.ready   = 1'b1;

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_valid", 64'(up_if.valid), 64'd0);
        check("rst_data", 64'(up_if.data), 64'd0);
        repeat (3) tick();

        // 2: basic send
        send(40'hAB_CDEF_0123, 8'h5A);
        lit("t2_f0", 16'h0123, 1'b0);
        tick();
        lit("t2_f1", 16'hCDEF, 1'b0);
        tick();
        lit("t2_f2", 16'h5AAB, 1'b1);
        check("t2_nobb_ready", 64'(ready), 64'd0);
        tick();
        check("t2_done_ready", 64'(ready), 64'd1);
        check("t2_done_valid", 64'(up_if.valid), 64'd0);

        // 3: backpressure on flit 1
        send(40'hAB_CDEF_0123, 8'h5A);
        lit("t3_f0", 16'h0123, 1'b0);
        tick();
        up_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("t3_hold", 16'hCDEF, 1'b0);
        end
        up_if.ready = 1'b1;
        tick();
        lit("t3_f2", 16'h5AAB, 1'b1);
        tick();

        // 4: flush with flit 1 pending, then a fresh word
        send(40'h11_2233_4455, 8'h66);
        tick();
        up_if.ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_valid", 64'(up_if.valid), 64'd0);
        check("t4_last", 64'(up_if.last), 64'd0);
        up_if.ready = 1'b1;
        tick();
        send(40'h11_2233_4455, 8'h66);
        lit("t4_new_f0", 16'h4455, 1'b0);
        tick();
        tick();
        lit("t4_new_f2", 16'h6611, 1'b1);
        tick();
        // Flush beats capture in idle
        flush = 1'b1;
        send(40'h12_3456_789A, 8'hBC);
        flush = 1'b0;
        check("t4_idle_flush_valid", 64'(up_if.valid), 64'd0);
        check("t4_idle_flush_ready", 64'(ready), 64'd1);
        tick();

        // 5: padding-free 20-bit word, partial final flit
        valid5  = 1'b1;
        packet5 = 20'hFEDCB;
        tick();
        valid5 = 1'b0;
        check("t5_f0_data", 64'(up5.data), 64'h0EDCB);
        check("t5_f0_last", 64'(up5.last), 64'd0);
        check("t5_busy", 64'(busy5), 64'd1);
        tick();
        check("t5_f1_data", 64'(up5.data), 64'h000F);
        check("t5_f1_last", 64'(up5.last), 64'd1);
        tick();
        check("t5_idle_valid", 64'(up5.valid), 64'd0);
        check("t5_idle_ready", 64'(ready5), 64'd1);

        // 6: reset during flit 1
        send(40'hAB_CDEF_0123, 8'h5A);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 64'(up_if.valid), 64'd0);
        check("t6_last", 64'(up_if.last), 64'd0);
        check("t6_data", 64'(up_if.data), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        repeat (3) tick();

        check("last_count_model", 64'(seen_lasts), 64'(exp_words));
        check("last_count_lit", 64'(seen_lasts), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
